ccsds_bit_serializer: RTL and testbench

Byte-to-bit serializer for the CCSDS TX chain, directly upstream of `bpsk_modulator`. It accepts bytes over a valid/ready handshake and emits them MSB-first as a `bit_o`/`valid_o` stream. Each bit is held for `cycles_per_bit` clocks, which matches the modulator's symbol pacing. A one-byte prefetch buffer lets consecutive bytes stream with no gap in `valid_o`.

---
 rtl/ccsds_bit_serializer_if.sv | 24 ++
 rtl/ccsds_bit_serializer.sv | 118 +++++++++++
 tb/tb_ccsds_bit_serializer.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ccsds_bit_serializer_if.sv
// Byte-in / bit-out bundle between the framer-side source and the bit serializer.
// The serializer takes the slave view, the byte source (or bench) the master view.
interface ccsds_bit_serializer_if #(
   parameter int DATA_WIDTH = 8,
   parameter int CNT_WIDTH  = 32
);
   logic [DATA_WIDTH-1:0] data_i;
   logic                  valid_i;
   logic                  ready_o;
   logic [CNT_WIDTH-1:0]  cycles_per_bit;
   logic                  bit_o;
   logic                  valid_o;
   logic [31:0]           bits_sent_o;

   modport master (
      output data_i, valid_i, cycles_per_bit,
      input  ready_o, bit_o, valid_o, bits_sent_o
   );

   modport slave (
      input  data_i, valid_i, cycles_per_bit,
      output ready_o, bit_o, valid_o, bits_sent_o
   );
endinterface

// File: rtl/ccsds_bit_serializer.sv
// MSB-first byte-to-bit serializer, each bit held n_lat clocks; first bit two edges after handshake.
// Backpressure: one-byte prefetch buffer, ready_o is low while the buffer holds a byte.
module ccsds_bit_serializer #(
   parameter int DATA_WIDTH = 8,
   parameter int CNT_WIDTH  = 32
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   ccsds_bit_serializer_if.slave     bus
);

   localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t                r_state,     w_state_nxt;
   logic [DATA_WIDTH-1:0] r_buf,       w_buf_nxt;
   logic                  r_buf_full,  w_buf_full_nxt;
   logic [DATA_WIDTH-1:0] r_sr,        w_sr_nxt;
   logic [BW-1:0]         r_bit_cnt,   w_bit_cnt_nxt;
   logic [CNT_WIDTH-1:0]  r_hold_cnt,  w_hold_nxt;
   logic [CNT_WIDTH-1:0]  r_n_lat,     w_n_lat_nxt;
   logic                  r_ready,     w_ready_nxt;
   logic [31:0]           r_bits_sent, w_bits_sent_nxt;

   logic                  w_accept;
   logic                  w_load;
   logic                  w_bit_done;
   logic [CNT_WIDTH-1:0]  w_n_new;

   assign w_accept   = bus.valid_i & r_ready;
   assign w_bit_done = (r_state == SHIFT) && (r_hold_cnt == r_n_lat - CNT_WIDTH'(1));
   assign w_n_new    = (bus.cycles_per_bit == '0) ? CNT_WIDTH'(1) : bus.cycles_per_bit;

   always_comb begin
      w_state_nxt     = r_state;
      w_buf_nxt       = r_buf;
      w_buf_full_nxt  = r_buf_full;
      w_sr_nxt        = r_sr;
      w_bit_cnt_nxt   = r_bit_cnt;
      w_hold_nxt      = r_hold_cnt;
      w_n_lat_nxt     = r_n_lat;
      w_bits_sent_nxt = r_bits_sent;
      w_load          = 1'b0;

      case (r_state)
         IDLE: begin
            w_load = r_buf_full;
         end
         SHIFT: begin
            w_hold_nxt = r_hold_cnt + CNT_WIDTH'(1);
            if (w_bit_done) begin
               w_hold_nxt      = '0;
               w_bits_sent_nxt = r_bits_sent + 32'd1;
               if (r_bit_cnt != LAST_BIT) begin
                  w_sr_nxt      = r_sr << 1;
                  w_bit_cnt_nxt = r_bit_cnt + BW'(1);
               end else if (r_buf_full) begin
                  w_load = 1'b1;
               end else begin
                  w_state_nxt = IDLE;
               end
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase

      // Accept needs an empty buffer and load needs a full one, so these never overlap.
      if (w_accept) begin
         w_buf_nxt      = bus.data_i;
         w_buf_full_nxt = 1'b1;
      end

      if (w_load) begin
         w_sr_nxt       = r_buf;
         w_buf_full_nxt = 1'b0;
         w_n_lat_nxt    = w_n_new;
         w_bit_cnt_nxt  = '0;
         w_hold_nxt     = '0;
         w_state_nxt    = SHIFT;
      end

      w_ready_nxt = ~w_buf_full_nxt;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state     <= IDLE;
         r_buf       <= '0;
         r_buf_full  <= 1'b0;
         r_sr        <= '0;
         r_bit_cnt   <= '0;
         r_hold_cnt  <= '0;
         r_n_lat     <= CNT_WIDTH'(1);
         r_ready     <= 1'b0;
         r_bits_sent <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_buf       <= w_buf_nxt;
         r_buf_full  <= w_buf_full_nxt;
         r_sr        <= w_sr_nxt;
         r_bit_cnt   <= w_bit_cnt_nxt;
         r_hold_cnt  <= w_hold_nxt;
         r_n_lat     <= w_n_lat_nxt;
         r_ready     <= w_ready_nxt;
         r_bits_sent <= w_bits_sent_nxt;
      end
   end

   assign bus.ready_o     = r_ready;
   assign bus.valid_o     = (r_state == SHIFT);
   assign bus.bit_o       = (r_state == SHIFT) & r_sr[DATA_WIDTH-1];
   assign bus.bits_sent_o = r_bits_sent;

endmodule

// File: tb/tb_ccsds_bit_serializer.sv
// Bench for ccsds_bit_serializer: directed scenarios plus a random byte stream,
// with the serial output compared against a queue of expected bits built per byte.
module tb_ccsds_bit_serializer;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   int n_cmp = 0;
   int n_err = 0;

   ccsds_bit_serializer_if #(.DATA_WIDTH(8), .CNT_WIDTH(32)) bus ();

   ccsds_bit_serializer #(.DATA_WIDTH(8), .CNT_WIDTH(32)) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   // Observed serial stream, sampled on the falling edge.
   logic q_obs[$];
   logic q_exp[$];
   int   valid_cycles = 0;
   int   valid_runs   = 0;
   logic prev_valid   = 1'b0;

   always @(negedge clk) begin
      if (bus.valid_o === 1'b1) begin
         q_obs.push_back(bus.bit_o);
         valid_cycles++;
         if (!prev_valid) valid_runs++;
      end
      prev_valid = (bus.valid_o === 1'b1);
   end

   // Reference: each byte contributes its bits MSB-first, each repeated max(n,1) times.
   function automatic void exp_byte(input logic [7:0] d, input int unsigned n);
      int unsigned reps;
      reps = (n == 0) ? 1 : n;
      for (int b = 7; b >= 0; b--)
         for (int unsigned r = 0; r < reps; r++)
            q_exp.push_back(d[b]);
   endfunction

   function automatic int first_diff();
      int lim;
      lim = (q_obs.size() < q_exp.size()) ? q_obs.size() : q_exp.size();
      for (int i = 0; i < lim; i++)
         if (q_obs[i] !== q_exp[i]) return i;
      if (q_obs.size() != q_exp.size()) return lim;
      return -1;
   endfunction

   task automatic clear_obs();
      q_obs.delete();
      q_exp.delete();
      valid_cycles = 0;
      valid_runs   = 0;
   endtask

   task automatic do_reset();
      rst_n              = 1'b0;
      bus.valid_i        = 1'b0;
      bus.data_i         = '0;
      bus.cycles_per_bit = 32'd1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic push(input logic [7:0] d);
      bit got;
      got = 1'b0;
      @(posedge clk);
      #1;
      bus.data_i  = d;
      bus.valid_i = 1'b1;
      for (int i = 0; i < 200 && !got; i++) begin
         @(negedge clk);
         if (bus.ready_o === 1'b1) got = 1'b1;
      end
      @(posedge clk);
      #1;
      bus.valid_i = 1'b0;
      if (!got) begin
         n_cmp++; n_err++;
         $display("FAIL push_timeout: byte %02h, ready_o never high in 200 cycles", d);
      end
   endtask

   task automatic wait_drain(input string tag);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 2000 && !ok; i++) begin
         @(negedge clk);
         if (bus.valid_o === 1'b0 && bus.ready_o === 1'b1) ok = 1'b1;
      end
      if (!ok) begin
         n_cmp++; n_err++;
         $display("FAIL %s_drain: serializer not idle after 2000 cycles", tag);
      end
   endtask

   task automatic check_stream(input string tag);
      int idx;
      idx = first_diff();
      n_cmp++;
      if (idx != -1) begin
         n_err++;
         $display("FAIL %s_stream: got %0d bits, expected %0d bits, first difference at bit %0d",
                  tag, q_obs.size(), q_exp.size(), idx);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.valid_i = 1'b0;
      bus.data_i = '0;
      bus.cycles_per_bit = 32'd1;
      #1;
      n_cmp++;
      if ({bus.ready_o, bus.valid_o, bus.bit_o} !== 3'b000) begin
         n_err++;
         $display("FAIL reset_outputs: ready/valid/bit = %b, required 000",
                  {bus.ready_o, bus.valid_o, bus.bit_o});
      end
      n_cmp++;
      if (bus.bits_sent_o !== 32'd0) begin
         n_err++;
         $display("FAIL reset_bits_sent: got %0d, required 0", bus.bits_sent_o);
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      n_cmp++;
      if (bus.ready_o !== 1'b0) begin
         n_err++;
         $display("FAIL reset_ready_before_edge: got %b, required 0", bus.ready_o);
      end
      @(negedge clk);
      n_cmp++;
      if (bus.ready_o !== 1'b1) begin
         n_err++;
         $display("FAIL reset_ready_after_edge: got %b, required 1", bus.ready_o);
      end
   endtask

   task automatic test_single_byte();
      do_reset();
      clear_obs();
      bus.cycles_per_bit = 32'd1;
      exp_byte(8'h8F, 1);
      push(8'h8F);
      n_cmp++;
      if (bus.ready_o !== 1'b0) begin
         n_err++;
         $display("FAIL single_ready_after_accept: got %b, required 0", bus.ready_o);
      end
      @(negedge clk);
      n_cmp++;
      if (bus.valid_o !== 1'b0) begin
         n_err++;
         $display("FAIL single_latency_early: valid_o %b one edge after handshake, required 0", bus.valid_o);
      end
      @(negedge clk);
      n_cmp++;
      if ({bus.valid_o, bus.bit_o} !== 2'b11) begin
         n_err++;
         $display("FAIL single_first_bit: valid/bit %b two edges after handshake, required 11",
                  {bus.valid_o, bus.bit_o});
      end
      wait_drain("single");
      check_stream("single");
      n_cmp++;
      if (valid_cycles != 8 || valid_runs != 1) begin
         n_err++;
         $display("FAIL single_valid_window: %0d cycles in %0d runs, required 8 in 1", valid_cycles, valid_runs);
      end
      n_cmp++;
      if (bus.bits_sent_o !== 32'd8) begin
         n_err++;
         $display("FAIL single_bits_sent: got %0d, required 8", bus.bits_sent_o);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] base;
      base = bus.bits_sent_o;
      clear_obs();
      bus.cycles_per_bit = 32'd1;
      exp_byte(8'h8F, 1);
      exp_byte(8'hA5, 1);
      push(8'h8F);
      push(8'hA5);
      n_cmp++;
      if (bus.ready_o !== 1'b0) begin
         n_err++;
         $display("FAIL b2b_ready_buffered: got %b, required 0 while a byte is buffered", bus.ready_o);
      end
      wait_drain("b2b");
      check_stream("b2b");
      n_cmp++;
      if (valid_cycles != 16 || valid_runs != 1) begin
         n_err++;
         $display("FAIL b2b_gapless: %0d cycles in %0d runs, required 16 in 1", valid_cycles, valid_runs);
      end
      n_cmp++;
      if (bus.bits_sent_o - base !== 32'd16) begin
         n_err++;
         $display("FAIL b2b_bits_sent: delta %0d, required 16", bus.bits_sent_o - base);
      end
   endtask

   task automatic test_hold6();
      clear_obs();
      bus.cycles_per_bit = 32'd6;
      exp_byte(8'h45, 6);
      push(8'h45);
      wait_drain("hold6");
      check_stream("hold6");
      n_cmp++;
      if (valid_cycles != 48 || valid_runs != 1) begin
         n_err++;
         $display("FAIL hold6_valid_window: %0d cycles in %0d runs, required 48 in 1", valid_cycles, valid_runs);
      end
   endtask

   task automatic test_zero_and_change();
      clear_obs();
      bus.cycles_per_bit = 32'd0;
      exp_byte(8'hC3, 1);
      exp_byte(8'h5A, 4);
      push(8'hC3);
      @(posedge clk);
      #1;
      bus.cycles_per_bit = 32'd4;
      push(8'h5A);
      wait_drain("zero_n");
      check_stream("zero_n");
      n_cmp++;
      if (valid_cycles != 40 || valid_runs != 1) begin
         n_err++;
         $display("FAIL zero_n_valid_window: %0d cycles in %0d runs, required 40 in 1", valid_cycles, valid_runs);
      end
   endtask

   task automatic test_reset_mid_byte();
      do_reset();
      clear_obs();
      bus.cycles_per_bit = 32'd2;
      push(8'hFF);
      push(8'h12);
      repeat (5) @(posedge clk);
      #2;
      n_cmp++;
      if ({bus.valid_o, bus.bit_o, bus.ready_o} !== 3'b110) begin
         n_err++;
         $display("FAIL midrst_before: valid/bit/ready %b, required 110", {bus.valid_o, bus.bit_o, bus.ready_o});
      end
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({bus.valid_o, bus.bit_o, bus.ready_o} !== 3'b000 || bus.bits_sent_o !== 32'd0) begin
         n_err++;
         $display("FAIL midrst_async: valid/bit/ready %b bits_sent %0d, required 000 and 0",
                  {bus.valid_o, bus.bit_o, bus.ready_o}, bus.bits_sent_o);
      end
      clear_obs();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      bus.cycles_per_bit = 32'd1;
      exp_byte(8'h3C, 1);
      push(8'h3C);
      wait_drain("midrst");
      repeat (4) @(negedge clk);
      check_stream("midrst");
      n_cmp++;
      if (bus.bits_sent_o !== 32'd8) begin
         n_err++;
         $display("FAIL midrst_bits_sent: got %0d, required 8", bus.bits_sent_o);
      end
   endtask

   task automatic test_random();
      logic [7:0] d;
      do_reset();
      clear_obs();
      for (int half = 0; half < 2; half++) begin
         bus.cycles_per_bit = (half == 0) ? 32'd1 : 32'd3;
         for (int i = 0; i < 32; i++) begin
            d = 8'($urandom);
            exp_byte(d, bus.cycles_per_bit);
            push(d);
            repeat ($urandom_range(0, 3)) @(posedge clk);
         end
         wait_drain("random");
      end
      check_stream("random");
      n_cmp++;
      if (bus.bits_sent_o !== 32'd512) begin
         n_err++;
         $display("FAIL random_bits_sent: got %0d, required 512", bus.bits_sent_o);
      end
   endtask

   initial begin
      test_reset();
      test_single_byte();
      test_back_to_back();
      test_hold6();
      test_zero_and_change();
      test_reset_mid_byte();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
